// File: rtl/fa_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fa_accumulator_pkg
// Description : Shared FSM state encoding for the burst accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package fa_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : fa_accumulator_pkg
`default_nettype wire

// File: rtl/fa_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : fa_accumulator_if
// Description : Operand/result valid-ready streams of the burst accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface fa_accumulator_if #(
    parameter int SIZE = 8
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_sum;
    logic            out_ovf;
    logic            busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface : fa_accumulator_if
`default_nettype wire

// File: rtl/fa_multi_bit.sv
`default_nettype none
// ============================================================================
// Module      : fa_multi_bit
// Description : SIZE-bit ripple-carry adder built from full-adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_multi_bit #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ci,
    output logic [SIZE-1:0] s,
    output logic [SIZE:0]   co
);

    // co[i] is the carry into bit i; co[SIZE] is the carry out of the MSB.
    always_comb begin
        logic c;
        c     = ci;
        co[0] = ci;
        s     = '0;
        for (int i = 0; i < SIZE; i++) begin
            s[i]    = a[i] ^ b[i] ^ c;
            c       = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            co[i+1] = c;
        end
    end

endmodule : fa_multi_bit
`default_nettype wire

// File: rtl/fa_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fa_accumulator
// Description : Sums a burst of COUNT operands; sum and sticky overflow out.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_accumulator
    import fa_accumulator_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int COUNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fa_accumulator_if.slave   bus
);

    localparam int CW = $clog2(COUNT + 1);

    state_t          state_q, state_d;
    logic [SIZE-1:0] acc_q,   acc_d;
    logic            ovf_q,   ovf_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic [SIZE-1:0] sum;
    logic [SIZE:0]   carry;
    logic            unused_low_carries;

    fa_multi_bit #(
        .SIZE (SIZE)
    ) u_adder (
        .a  (acc_q),
        .b  (bus.in_data),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    assign unused_low_carries = ^carry[SIZE-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    acc_d = sum;
                    ovf_d = ovf_q | carry[SIZE];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(COUNT - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode only the state register.
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule : fa_accumulator
`default_nettype wire

// File: tb/tb_fa_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa_accumulator
// Description : Directed and randomised bursts against fa_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_accumulator;
    import fa_accumulator_pkg::*;

    localparam int SIZE  = 8;
    localparam int COUNT = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    fa_accumulator_if #(.SIZE(SIZE)) bus ();

    fa_accumulator #(
        .SIZE  (SIZE),
        .COUNT (COUNT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ops holds operand i in byte i; gap < 0 selects a random 0..2 idle cycles per beat.
    task automatic burst(input string tag, input logic [31:0] ops, input int gap,
                         input int hold, input bit spur, input bit vstart,
                         input logic [7:0] es, input bit eo);
        int g;
        bus.start = 1'b1;
        if (vstart) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h55;
        end
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        for (int i = 0; i < COUNT; i++) begin
            g = (gap < 0) ? $urandom_range(2, 0) : gap;
            for (int k = 0; k < g; k++) tick();
            bus.in_valid = 1'b1;
            bus.in_data  = ops[8*i +: 8];
            if (spur && i == 1) bus.start = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
        end
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_sum"}, bus.out_sum, es);
        check({tag, "_ovf"}, bus.out_ovf, eo);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            tick();
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_sum"}, bus.out_sum, es);
            check({tag, "_hold_ovf"}, bus.out_ovf, eo);
            check({tag, "_hold_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        if (spur) bus.start = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check({tag, "_idle_valid"}, bus.out_valid, 0);
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_idle_sum"}, bus.out_sum, es);
        if (spur) begin
            tick();
            check({tag, "_spur_state"}, dut.state_q, ST_IDLE);
            check({tag, "_spur_in_ready"}, bus.in_ready, 0);
        end
    endtask

    initial begin
        logic [31:0] ops;
        int          total;
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_sum", bus.out_sum, 0);
        check("rst_ovf", bus.out_ovf, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", dut.state_q, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_in_ready", bus.in_ready, 0);

        burst("basic", 32'h40302010, 0, 0, 0, 0, 8'hA0, 0);
        burst("ovf80", 32'h02018080, 0, 0, 0, 0, 8'h03, 1);
        burst("ovfff", 32'hFFFFFFFF, 0, 1, 0, 0, 8'hFC, 1);
        burst("gaps",  32'h0F0E0D0C, 2, 5, 0, 0, 8'h36, 0);

        // Abort after two beats: outputs must clear without a clock edge.
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hF0;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum", bus.out_sum, 0);
        check("arst_ovf", bus.out_ovf, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_out_valid", bus.out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        burst("after_rst", 32'h04030201, 0, 0, 0, 0, 8'h0A, 0);

        burst("spur",   32'h11111111, 1, 2, 1, 0, 8'h44, 0);
        burst("vstart", 32'h01010101, 0, 0, 0, 1, 8'h04, 0);

        for (int b = 0; b < 200; b++) begin
            ops   = $urandom;
            total = 0;
            for (int i = 0; i < COUNT; i++) total += int'(ops[8*i +: 8]);
            burst("rand", ops, -1, $urandom_range(3, 0), 0, 0, total[7:0], total > 255);
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fa_accumulator
`default_nettype wire
